// File: rtl/network_bf_out_n.sv
// Output crossbar for a bank of radix-2 butterflies: per-lane selects are
// delayed by the butterfly latency, then each lane picks any butterfly
// upper/lower result and registers it with an aligned valid.

// One output lane: (2*NUM_BF):1 source mux feeding the lane register.
module network_bf_out_n_lane #(
  parameter int data_width = 14,
  parameter int NUM_BF     = 2,
  parameter int SEL_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ld,
  input  logic [SEL_W-1:0]             sel,
  input  logic [NUM_BF*data_width-1:0] bf_upper,
  input  logic [NUM_BF*data_width-1:0] bf_lower,
  output logic [data_width-1:0]        dout
);

  logic [data_width-1:0] mux;

  // Even index -> lower of unit s/2, odd -> upper; anything past the last
  // source falls through to zero.
  always_comb begin
    mux = '0;
    for (int j = 0; j < NUM_BF; j++) begin
      if (sel == SEL_W'(2*j))   mux = bf_lower[j*data_width +: data_width];
      if (sel == SEL_W'(2*j+1)) mux = bf_upper[j*data_width +: data_width];
    end
  end

  // Lane register loads only on an aligned valid, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     dout <= '0;
    else if (ld) dout <= mux;
  end

endmodule

module network_bf_out_n #(
  parameter  int data_width = 14,
  parameter  int NUM_BF     = 2,
  parameter  int BF_LAT     = 7,
  localparam int NUM_LANES  = 2*NUM_BF,
  localparam int SEL_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_BF*data_width-1:0]    bf_upper,
  input  logic [NUM_BF*data_width-1:0]    bf_lower,
  input  logic [NUM_LANES*SEL_W-1:0]      sel,
  input  logic                            sel_valid,
  output logic [NUM_LANES*data_width-1:0] dout,
  output logic                            dout_valid
);

  logic [BF_LAT-1:0][NUM_LANES*SEL_W-1:0] sel_pipe;
  logic [BF_LAT-1:0]                      vld_pipe;
  logic [NUM_LANES*SEL_W-1:0]             sel_al;
  logic                                   vld_al;
  logic [NUM_LANES-1:0][data_width-1:0]   lane_q;

  // Select/valid delay line matching the butterfly latency; never stalls,
  // and reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_pipe <= '0;
      vld_pipe <= '0;
    end else begin
      sel_pipe[0] <= sel;
      vld_pipe[0] <= sel_valid;
      for (int i = 1; i < BF_LAT; i++) begin
        sel_pipe[i] <= sel_pipe[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign sel_al = sel_pipe[BF_LAT-1];
  assign vld_al = vld_pipe[BF_LAT-1];

  // Output valid tracks the aligned valid one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dout_valid <= 1'b0;
    else     dout_valid <= vld_al;
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    network_bf_out_n_lane #(
      .data_width (data_width),
      .NUM_BF     (NUM_BF),
      .SEL_W      (SEL_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .ld       (vld_al),
      .sel      (sel_al[k*SEL_W +: SEL_W]),
      .bf_upper (bf_upper),
      .bf_lower (bf_lower),
      .dout     (lane_q[k])
    );
  end

  assign dout = lane_q;

endmodule

// File: tb/tb_network_bf_out_n.sv
// Bench for network_bf_out_n: three parameterisations driven from directed
// and random vector tables; expected lanes are queued at issue and checked
// by a monitor whenever dout_valid is seen, including exact latency.
module tb_network_bf_out_n;

  localparam int DW = 14;

  typedef struct {
    bit          v;
    int          s[8];
    logic [DW-1:0] u[4];
    logic [DW-1:0] l[4];
  } vec_t;

  typedef struct {
    int          cyc;
    logic [DW-1:0] d[8];
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  vec_t          prog[3][$];
  exp_t          sb[3][$];
  logic [DW-1:0] last[3][8];
  int            sel_t[3][8];
  bit            v_t[3];
  logic [DW-1:0] up_t[3][4];
  logic [DW-1:0] lo_t[3][4];
  logic [DW-1:0] got[3][8];
  logic          gv[3];

  // DUT A: NUM_BF=2, BF_LAT=7; B: NUM_BF=3, BF_LAT=1; C: NUM_BF=1, BF_LAT=12
  logic [2*DW-1:0] up_a, lo_a;
  logic [7:0]      sel_a;
  logic [4*DW-1:0] dout_a;
  logic            va, dv_a;
  logic [3*DW-1:0] up_b, lo_b;
  logic [17:0]     sel_b;
  logic [6*DW-1:0] dout_b;
  logic            vb, dv_b;
  logic [DW-1:0]   up_c, lo_c;
  logic [1:0]      sel_c;
  logic [2*DW-1:0] dout_c;
  logic            vc, dv_c;

  network_bf_out_n #(.data_width(DW), .NUM_BF(2), .BF_LAT(7)) u_a (
    .clk(clk), .rst(rst), .bf_upper(up_a), .bf_lower(lo_a), .sel(sel_a),
    .sel_valid(va), .dout(dout_a), .dout_valid(dv_a));
  network_bf_out_n #(.data_width(DW), .NUM_BF(3), .BF_LAT(1)) u_b (
    .clk(clk), .rst(rst), .bf_upper(up_b), .bf_lower(lo_b), .sel(sel_b),
    .sel_valid(vb), .dout(dout_b), .dout_valid(dv_b));
  network_bf_out_n #(.data_width(DW), .NUM_BF(1), .BF_LAT(12)) u_c (
    .clk(clk), .rst(rst), .bf_upper(up_c), .bf_lower(lo_c), .sel(sel_c),
    .sel_valid(vc), .dout(dout_c), .dout_valid(dv_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // pack per-DUT stimulus arrays onto the ports
  always_comb begin
    sel_a = '0; sel_b = '0; sel_c = '0;
    up_a = '0; lo_a = '0; up_b = '0; lo_b = '0;
    for (int i = 0; i < 4; i++) sel_a[i*2 +: 2] = 2'(sel_t[0][i]);
    for (int i = 0; i < 6; i++) sel_b[i*3 +: 3] = 3'(sel_t[1][i]);
    for (int i = 0; i < 2; i++) sel_c[i]        = 1'(sel_t[2][i]);
    for (int i = 0; i < 2; i++) begin up_a[i*DW +: DW] = up_t[0][i]; lo_a[i*DW +: DW] = lo_t[0][i]; end
    for (int i = 0; i < 3; i++) begin up_b[i*DW +: DW] = up_t[1][i]; lo_b[i*DW +: DW] = lo_t[1][i]; end
    up_c = up_t[2][0];
    lo_c = lo_t[2][0];
    va = v_t[0]; vb = v_t[1]; vc = v_t[2];
  end

  // unpack DUT outputs into per-lane arrays
  always_comb begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) got[k][i] = '0;
    for (int i = 0; i < 4; i++) got[0][i] = dout_a[i*DW +: DW];
    for (int i = 0; i < 6; i++) got[1][i] = dout_b[i*DW +: DW];
    for (int i = 0; i < 2; i++) got[2][i] = dout_c[i*DW +: DW];
    gv[0] = dv_a; gv[1] = dv_b; gv[2] = dv_c;
  end

  function automatic int nl(int k);
    return (k == 0) ? 4 : (k == 1) ? 6 : 2;
  endfunction

  // reference routing: even -> lower[s/2], odd -> upper[s/2], out of range -> 0
  function automatic logic [DW-1:0] pick(int nbf, vec_t x, int lane);
    int s;
    s = x.s[lane];
    if (s >= 2*nbf) return '0;
    return (s % 2 == 1) ? x.u[s/2] : x.l[s/2];
  endfunction

  // sp: lane selects as hex nibbles (lane0 lowest); up/lp: 14-bit fields, unit0 lowest
  function automatic vec_t mk(bit v, bit [31:0] sp, bit [55:0] up, bit [55:0] lp);
    vec_t x;
    x.v = v;
    for (int i = 0; i < 8; i++) x.s[i] = int'(sp[i*4 +: 4]);
    for (int i = 0; i < 4; i++) begin x.u[i] = up[i*14 +: 14]; x.l[i] = lp[i*14 +: 14]; end
    return x;
  endfunction

  function automatic vec_t rnd(int smax);
    vec_t x;
    x.v = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < 8; i++) x.s[i] = int'($urandom_range(0, smax));
    for (int i = 0; i < 4; i++) begin x.u[i] = DW'($urandom); x.l[i] = DW'($urandom); end
    return x;
  endfunction

  // Issue selects each cycle; butterfly data for vector j shows up lat cycles
  // later, as a real butterfly of that latency would deliver it.
  task automatic drive(int k, int lat, int nbf);
    int n;
    n = prog[k].size();
    for (int j = 0; j < n + lat; j++) begin
      @(posedge clk); #1;
      v_t[k] = 1'b0;
      if (j < n) begin
        v_t[k] = prog[k][j].v;
        for (int i = 0; i < 8; i++) sel_t[k][i] = prog[k][j].s[i];
        if (prog[k][j].v) begin
          exp_t e;
          e.cyc = cyc + lat + 1;
          for (int i = 0; i < 8; i++) e.d[i] = (i < 2*nbf) ? pick(nbf, prog[k][j], i) : '0;
          sb[k].push_back(e);
        end
      end
      if (j >= lat && j - lat < n)
        for (int u = 0; u < 4; u++) begin
          up_t[k][u] = prog[k][j-lat].u[u];
          lo_t[k][u] = prog[k][j-lat].l[u];
        end
    end
  endtask

  task automatic check_rst(string tag);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (gv[k] !== 1'b0) begin
        bad++;
        $display("FAIL %s dut%0d dout_valid got %b want 0", tag, k, gv[k]);
      end
      for (int i = 0; i < nl(k); i++) begin
        total++;
        if (got[k][i] !== '0) begin
          bad++;
          $display("FAIL %s dut%0d lane%0d got %h want 0", tag, k, i, got[k][i]);
        end
      end
    end
  endtask

  task automatic mon(int k);
    exp_t e;
    if (gv[k]) begin
      total++;
      if (sb[k].size() == 0) begin
        bad++;
        $display("FAIL dut%0d spurious dout_valid at cyc %0d, want none", k, cyc);
      end else begin
        e = sb[k].pop_front();
        if (cyc != e.cyc) begin
          bad++;
          $display("FAIL dut%0d latency: output at cyc %0d want cyc %0d", k, cyc, e.cyc);
        end
        for (int i = 0; i < nl(k); i++) begin
          total++;
          if (got[k][i] !== e.d[i]) begin
            bad++;
            $display("FAIL dut%0d route lane%0d got %h want %h (cyc %0d)", k, i, got[k][i], e.d[i], cyc);
          end
        end
        for (int i = 0; i < 8; i++) last[k][i] = e.d[i];
      end
    end else begin
      for (int i = 0; i < nl(k); i++) begin
        total++;
        if (got[k][i] !== last[k][i]) begin
          bad++;
          $display("FAIL dut%0d hold lane%0d got %h want %h (cyc %0d)", k, i, got[k][i], last[k][i], cyc);
        end
      end
    end
  endtask

  // monitor: checks every non-reset cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst)
      for (int k = 0; k < 3; k++) mon(k);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      v_t[k] = 1'b0;
      for (int i = 0; i < 8; i++) begin sel_t[k][i] = 0; last[k][i] = '0; end
      for (int u = 0; u < 4; u++) begin up_t[k][u] = '0; lo_t[k][u] = '0; end
    end

    // A: permutation, broadcast, distinct patterns, 2-cycle gap, then random
    prog[0].push_back(mk(1, 32'h3210, {14'h0, 14'h0, 14'h11, 14'h10}, {14'h0, 14'h0, 14'h21, 14'h20}));
    prog[0].push_back(mk(1, 32'h1111, {14'h0, 14'h0, 14'h11, 14'h10}, {14'h0, 14'h0, 14'h21, 14'h20}));
    prog[0].push_back(mk(1, 32'h0123, {14'h0, 14'h0, 14'h3A1, 14'h3A0}, {14'h0, 14'h0, 14'h3B1, 14'h3B0}));
    prog[0].push_back(mk(1, 32'h2301, {14'h0, 14'h0, 14'h0C1, 14'h0C0}, {14'h0, 14'h0, 14'h0D1, 14'h0D0}));
    prog[0].push_back(mk(1, 32'h3300, {14'h0, 14'h0, 14'h1E1, 14'h1E0}, {14'h0, 14'h0, 14'h1F1, 14'h1F0}));
    prog[0].push_back(mk(0, 32'h2222, {14'h0, 14'h0, 14'h3FFF, 14'h3FFE}, {14'h0, 14'h0, 14'h3FFD, 14'h3FFC}));
    prog[0].push_back(mk(0, 32'h0000, {14'h0, 14'h0, 14'h2AAA, 14'h1555}, {14'h0, 14'h0, 14'h0F0F, 14'h30F0}));
    prog[0].push_back(mk(1, 32'h1032, {14'h0, 14'h0, 14'h0041, 14'h0040}, {14'h0, 14'h0, 14'h0051, 14'h0050}));
    for (int j = 0; j < 24; j++) prog[0].push_back(rnd(3));

    // B: six lanes, lane 0 out of range (6 then 7), others normal, then random incl. 6/7
    prog[1].push_back(mk(1, 32'h0054_3216, {14'h0, 14'h102, 14'h101, 14'h100}, {14'h0, 14'h202, 14'h201, 14'h200}));
    prog[1].push_back(mk(1, 32'h0001_2347, {14'h0, 14'h302, 14'h301, 14'h300}, {14'h0, 14'h402, 14'h401, 14'h400}));
    for (int j = 0; j < 24; j++) prog[1].push_back(rnd(7));

    // C: single butterfly, lane1 takes upper, lane0 takes lower
    prog[2].push_back(mk(1, 32'h10, {14'h0, 14'h0, 14'h0, 14'h1234}, {14'h0, 14'h0, 14'h0, 14'h0ABC}));
    for (int j = 0; j < 16; j++) prog[2].push_back(rnd(1));

    // asynchronous power-on reset, checked before any clock edge
    #2 rst = 1'b1;
    #1 check_rst("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    fork
      drive(0, 7, 2);
      drive(1, 1, 3);
      drive(2, 12, 1);
    join
    repeat (4) @(posedge clk);

    // reset in the middle of a stream: in-flight selects must vanish
    prog[0].delete();
    for (int j = 0; j < 4; j++) begin
      prog[0].push_back(rnd(3));
      prog[0][j].v = 1'b1;
    end
    fork
      drive(0, 7, 2);
      begin
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_rst("mid_reset");
        for (int k = 0; k < 3; k++) begin
          sb[k].delete();
          for (int i = 0; i < 8; i++) last[k][i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    repeat (4) @(posedge clk);

    // fresh issue after reset on every DUT, exact latency still required
    for (int k = 0; k < 3; k++) begin
      prog[k].delete();
      prog[k].push_back(rnd((k == 0) ? 3 : (k == 1) ? 7 : 1));
      prog[k][0].v = 1'b1;
    end
    fork
      drive(0, 7, 2);
      drive(1, 1, 3);
      drive(2, 12, 1);
    join
    repeat (4) @(posedge clk);

    for (int k = 0; k < 3; k++) begin
      total++;
      if (sb[k].size() != 0) begin
        bad++;
        $display("FAIL dut%0d missing outputs: %0d pending, want 0", k, sb[k].size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/network_bf_out_n.md
# network_bf_out_n

Parametrised output crossbar for a bank of `NUM_BF` radix-2 butterfly units in the NTT datapath. Each output lane gets a per-lane source select, issued together with the butterfly inputs. The block delays those selects by the butterfly pipeline latency `BF_LAT` and routes any butterfly upper/lower result to any output lane. It registers the routed data with an aligned valid flag before the memory write-back stage.

## Interface
- `data_width`, 14: coefficient width in bits.
- `NUM_BF`, 2: number of butterfly units; there are `2*NUM_BF` output lanes. Must be ≥1.
- `BF_LAT`, 7: butterfly pipeline latency in cycles, i.e. the select/valid delay depth. Must be ≥1.
- `SEL_W`, derived localparam = max(1, clog2(2*NUM_BF)): per-lane select width.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `bf_upper` in `NUM_BF*data_width`: butterfly upper results; unit i occupies bits [i*data_width +: data_width].
- `bf_lower` in `NUM_BF*data_width`: butterfly lower results, same packing.
- `sel` in `2*NUM_BF*SEL_W`: per-lane source index; lane k occupies bits [k*SEL_W +: SEL_W]. Issued in the same cycle as the butterfly operands.
- `sel_valid` in 1: qualifies `sel`; issued with the butterfly operands.
- `dout` out `2*NUM_BF*data_width`: routed, registered lane outputs; lane k occupies bits [k*data_width +: data_width].
- `dout_valid` out 1: `dout` holds a new routed result this cycle.

## Operation
- **Source index s:**
  - s even selects `bf_lower` of unit s/2.
  - s odd selects `bf_upper` of unit (s-1)/2.
  - s ≥ 2*NUM_BF is out of range; the lane is driven to 0.
  - With `NUM_BF`=1, `SEL_W`=1, sel=1 selects upper and sel=0 selects lower.
- **Delay line:** `sel` and `sel_valid` enter a `BF_LAT`-stage shift register that advances every cycle with no stall. Stage 0 captures the inputs; stage `BF_LAT`-1 is the aligned select.
- **Routing:** combinational muxes use the aligned select against the current `bf_upper`/`bf_lower`.
- **Output register:**
  - When the aligned valid is 1, the muxed lanes load into `dout` and `dout_valid`=1 on the next edge.
  - When the aligned valid is 0, `dout` holds its previous value and `dout_valid`=0.
- **Fan-out:** lanes are independent. Several lanes may select the same source (broadcast), and any permutation is legal.
- **Reset:**
  - All delay-line stages clear: sel=0, valid=0.
  - `dout`=0 and `dout_valid`=0 immediately, without waiting for a clock edge.
  - Selects in flight when `rst` asserts are discarded. After release, the first `dout_valid` appears no earlier than `BF_LAT`+1 cycles after the first post-reset `sel_valid`.
- There is no internal state machine beyond the delay line. Back-to-back valid issues every cycle sustain full throughput.

## Timing
- **Latency:** `sel`/`sel_valid` sampled at edge t are routed against the butterfly data present between edges t+`BF_LAT`-1 and t+`BF_LAT`. The result appears on `dout` with `dout_valid`=1 after edge t+`BF_LAT`, giving a total of `BF_LAT`+1 cycles from issue to output.
- **Data alignment:** butterfly data must be stable in the cycle before that edge. This holds by construction because the butterfly has latency `BF_LAT`.
- **Throughput:** one routing per cycle.
- **Valid gaps:** a gap of n cycles in `sel_valid` produces exactly n cycles of `dout_valid`=0 at the output, `BF_LAT`+1 cycles later.
- **Reset values:** `dout`=0, `dout_valid`=0.
- **Critical path:** a single (2*NUM_BF):1 mux level per lane into a register.

## Test plan
- **Legacy equivalence:** `NUM_BF`=1, `BF_LAT`=7, upper=0x1234, lower=0x0ABC. Issue sel={lane1=1, lane0=0} with valid at cycle 0 → at cycle 8, `dout`={0x1234, 0x0ABC} with `dout_valid`=1; `dout_valid`=0 on cycles 1–7.
- **Permutation/broadcast:** `NUM_BF`=2, upper={u1=0x11, u0=0x10}, lower={l1=0x21, l0=0x20}. Lanes select {3,2,1,0} → {0x11, 0x21, 0x10, 0x20}. Lanes select {1,1,1,1} → all lanes 0x10.
- **Out of range:** `NUM_BF`=3 (6 lanes, `SEL_W`=3). Lane 0 sel=6 or 7 → lane 0 = 0; the other lanes route normally.
- **Streaming with gap:** valid on cycles 0–4, off on 5–6, on on 7, each cycle with a distinct select pattern → `dout_valid` high on cycles 8–12 and 15, low on 13–14. `dout` holds the cycle-12 value through cycles 13–14, and each valid output matches its issue-cycle pattern.
- **Reset mid-stream:** issue valid selects on cycles 0–3 and assert `rst` asynchronously in cycle 4 → `dout`=0 and `dout_valid`=0 immediately. After release, no `dout_valid` appears until `BF_LAT`+1 cycles after a fresh `sel_valid`.
- **Parameter sweep:** `BF_LAT`∈{1,7,12}, `NUM_BF`∈{1,2,4}, random selects and data against a reference model → all outputs match, with latency exactly `BF_LAT`+1.
